// File: rtl/piezo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piezo_pkg
// Description : Shared types and constants for the piezo sound scheduler:
//               note half-periods, scheduler state encoding, note ROM entry
//               layout and small arbitration helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package piezo_pkg;

   // Half-periods in clk cycles at a 1 MHz clock
   localparam logic [15:0] c_c4_half = 16'd1911;
   localparam logic [15:0] c_d4_half = 16'd1703;
   localparam logic [15:0] c_e4_half = 16'd1517;
   localparam logic [15:0] c_g4_half = 16'd1276;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_PLAY = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // One note of a pattern; period of zero is a rest
   typedef struct packed {
      logic [15:0] period;
      logic [9:0]  dur_ms;
      logic        last;
   } note_entry_t;

   localparam int c_entry_w = $bits(note_entry_t);

   function automatic logic [2:0] onehot3(input logic [1:0] src);
      return 3'b001 << src;
   endfunction

   // Fixed priority: bit 0 is the most important requester
   function automatic logic [1:0] lowest_set(input logic [2:0] r);
      if (r[0])
         return 2'd0;
      else if (r[1])
         return 2'd1;
      else
         return 2'd2;
   endfunction

   // Requesters that outrank the given source
   function automatic logic [2:0] below_mask(input logic [1:0] src);
      return onehot3(src) - 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piezo_note_rom.sv
`default_nettype none
// ============================================================================
// Module      : piezo_note_rom
// Description : Combinational note pattern table for the three requesters.
//               src 0 = alarm, 1 = key beep, 2 = melody; idx = note position.
//               Unused slots return a 1 ms rest flagged as last, so a stray
//               lookup still terminates a pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_note_rom
   import piezo_pkg::*;
(
   input  logic [1:0]           src,
   input  logic [2:0]           idx,
   output logic [c_entry_w-1:0] entry
);

   note_entry_t w_entry;

   // Pattern lookup keyed by requester and note position
   always_comb begin
      w_entry = '{period: 16'd0, dur_ms: 10'd1, last: 1'b1};
      case ({src, idx})
         5'b00_000: w_entry = '{period: c_e4_half, dur_ms: 10'd100,  last: 1'b0};
         5'b00_001: w_entry = '{period: c_c4_half, dur_ms: 10'd100,  last: 1'b1};
         5'b01_000: w_entry = '{period: c_d4_half, dur_ms: 10'd50,   last: 1'b1};
         5'b10_000: w_entry = '{period: c_c4_half, dur_ms: 10'd500,  last: 1'b0};
         5'b10_001: w_entry = '{period: c_d4_half, dur_ms: 10'd500,  last: 1'b0};
         5'b10_010: w_entry = '{period: c_e4_half, dur_ms: 10'd500,  last: 1'b0};
         5'b10_011: w_entry = '{period: c_c4_half, dur_ms: 10'd500,  last: 1'b0};
         5'b10_100: w_entry = '{period: c_g4_half, dur_ms: 10'd1000, last: 1'b1};
         default:   w_entry = '{period: 16'd0,     dur_ms: 10'd1,    last: 1'b1};
      endcase
   end

   assign entry = w_entry;

endmodule
`default_nettype wire

// File: rtl/piezo_sound_sched.sv
`default_nettype none
// ============================================================================
// Module      : piezo_sound_sched
// Description : Fixed-priority scheduler for the shared piezo tone generator.
//               Grants one of alarm / key beep / melody, plays its note
//               pattern from piezo_note_rom and drives tone_en/tone_period.
//               Optional build macro PIEZO_PREEMPT_EN lets a higher-priority
//               request abort the pattern currently playing.
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_sound_sched
   import piezo_pkg::*;
#(
   parameter int TICK_CYC = 1000,
   parameter int GAP_MS   = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   output logic [2:0]  grant,
   output logic [2:0]  done,
   output logic        busy,
   output logic        tone_en,
   output logic [15:0] tone_period
);

   localparam logic [9:0] c_tick_last = 10'(TICK_CYC - 1);
   localparam logic [9:0] c_gap_last  = 10'(GAP_MS - 1);

   state_e      state_q, state_d;
   logic [1:0]  winner_q, winner_d;
   logic [2:0]  note_idx_q, note_idx_d;
   logic [9:0]  presc_q, presc_d;
   logic [9:0]  ms_q, ms_d;
   logic [2:0]  grant_q, grant_d;
   logic [2:0]  done_q, done_d;
   logic        tone_en_q, tone_en_d;
   logic [15:0] tone_period_q, tone_period_d;

   logic [c_entry_w-1:0] w_entry_bits;
   note_entry_t          w_entry;
   logic                 w_tick;
   logic                 w_serving;
   logic                 w_abort;

   piezo_note_rom u_note_rom (
      .src   (winner_q),
      .idx   (note_idx_q),
      .entry (w_entry_bits)
   );

   assign w_entry   = note_entry_t'(w_entry_bits);
   assign w_tick    = (presc_q == c_tick_last);
   assign w_serving = (state_q == ST_LOAD) || (state_q == ST_PLAY) || (state_q == ST_GAP);

   // Abort when the served requester lets go, or when a more important one shows up
   always_comb begin
      w_abort = ~req[winner_q];
`ifdef PIEZO_PREEMPT_EN
      w_abort = w_abort | (|(req & below_mask(winner_q)));
`endif
   end

   // Next-state and output decode for the scheduler
   always_comb begin
      state_d       = state_q;
      winner_d      = winner_q;
      note_idx_d    = note_idx_q;
      presc_d       = presc_q;
      ms_d          = ms_q;
      grant_d       = grant_q;
      done_d        = 3'b000;
      tone_en_d     = tone_en_q;
      tone_period_d = tone_period_q;

      if (w_serving && w_abort) begin
         // Silent return to idle; no completion pulse
         state_d   = ST_IDLE;
         grant_d   = 3'b000;
         tone_en_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  winner_d   = lowest_set(req);
                  grant_d    = onehot3(lowest_set(req));
                  note_idx_d = 3'd0;
                  state_d    = ST_LOAD;
               end
            end
            ST_LOAD: begin
               tone_period_d = w_entry.period;
               tone_en_d     = (w_entry.period != 16'd0);
               presc_d       = 10'd0;
               ms_d          = 10'd0;
               state_d       = ST_PLAY;
            end
            ST_PLAY: begin
               presc_d = w_tick ? 10'd0 : presc_q + 10'd1;
               if (w_tick) begin
                  if (ms_q == w_entry.dur_ms - 10'd1) begin
                     tone_en_d = 1'b0;
                     presc_d   = 10'd0;
                     ms_d      = 10'd0;
                     if (w_entry.last) begin
                        done_d  = onehot3(winner_q);
                        state_d = ST_DONE;
                     end else begin
                        note_idx_d = note_idx_q + 3'd1;
                        state_d    = ST_GAP;
                     end
                  end else begin
                     ms_d = ms_q + 10'd1;
                  end
               end
            end
            ST_GAP: begin
               presc_d = w_tick ? 10'd0 : presc_q + 10'd1;
               if (w_tick) begin
                  if (ms_q == c_gap_last)
                     state_d = ST_LOAD;
                  else
                     ms_d = ms_q + 10'd1;
               end
            end
            ST_DONE: begin
               grant_d   = 3'b000;
               tone_en_d = 1'b0;
               state_d   = ST_IDLE;
            end
            default: begin
               state_d   = ST_IDLE;
               grant_d   = 3'b000;
               tone_en_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         winner_q      <= 2'd0;
         note_idx_q    <= 3'd0;
         presc_q       <= 10'd0;
         ms_q          <= 10'd0;
         grant_q       <= 3'b000;
         done_q        <= 3'b000;
         tone_en_q     <= 1'b0;
         tone_period_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         winner_q      <= winner_d;
         note_idx_q    <= note_idx_d;
         presc_q       <= presc_d;
         ms_q          <= ms_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         tone_en_q     <= tone_en_d;
         tone_period_q <= tone_period_d;
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign busy        = (state_q != ST_IDLE);
   assign tone_en     = tone_en_q;
   assign tone_period = tone_period_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_sound_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_piezo_sound_sched
// Description : Self-checking bench for piezo_sound_sched. A timeline model
//               expands each granted pattern into run-length segments of
//               expected outputs and compares every cycle. Honours
//               PIEZO_PREEMPT_EN the same way the design build does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piezo_sound_sched;

   localparam int TICK = 10;
   localparam int GAPM = 2;

   localparam int K_IDLE = 0;
   localparam int K_LOAD = 1;
   localparam int K_PLAY = 2;
   localparam int K_GAP  = 3;
   localparam int K_DONE = 4;

   typedef struct {
      int kind;
      int per;
      int cnt;
   } seg_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic        busy;
   logic        tone_en;
   logic [15:0] tone_period;

   piezo_sound_sched #(
      .TICK_CYC (TICK),
      .GAP_MS   (GAPM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .done        (done),
      .busy        (busy),
      .tone_en     (tone_en),
      .tone_period (tone_period)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   seg_t        segs[$];
   int          cur_kind   = K_IDLE;
   int          win        = 0;
   logic [2:0]  exp_grant  = 3'b000;
   logic [2:0]  exp_done   = 3'b000;
   logic        exp_en     = 1'b0;
   logic [15:0] exp_period = 16'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, expv);
      end
   endtask

   task automatic add_seg(input int kind, input int per, input int cnt);
      seg_t s;
      s.kind = kind;
      s.per  = per;
      s.cnt  = cnt;
      segs.push_back(s);
   endtask

   // One note: a fetch cycle, the tone itself, then a gap or the completion cycle
   task automatic add_note(input int per, input int dur_ms, input bit last);
      add_seg(K_LOAD, 0, 1);
      add_seg(K_PLAY, per, dur_ms * TICK);
      if (last)
         add_seg(K_DONE, 0, 1);
      else
         add_seg(K_GAP, 0, GAPM * TICK);
   endtask

   task automatic build_plan(input int w);
      segs.delete();
      case (w)
         0: begin
            add_note(1517, 100, 1'b0);
            add_note(1911, 100, 1'b1);
         end
         1: add_note(1703, 50, 1'b1);
         default: begin
            add_note(1911, 500, 1'b0);
            add_note(1703, 500, 1'b0);
            add_note(1517, 500, 1'b0);
            add_note(1911, 500, 1'b0);
            add_note(1276, 1000, 1'b1);
         end
      endcase
   endtask

   task automatic go_idle();
      segs.delete();
      cur_kind  = K_IDLE;
      exp_grant = 3'b000;
      exp_done  = 3'b000;
      exp_en    = 1'b0;
   endtask

   task automatic advance();
      seg_t s;
      if (segs.size() == 0) begin
         go_idle();
      end else begin
         s        = segs.pop_front();
         cur_kind = s.kind;
         if (s.kind == K_PLAY) begin
            exp_period = 16'(s.per);
            exp_en     = (s.per != 0);
         end else begin
            exp_en = 1'b0;
         end
         exp_done = (s.kind == K_DONE) ? 3'(1 << win) : 3'b000;
         s.cnt--;
         if (s.cnt > 0)
            segs.push_front(s);
      end
   endtask

   // Expected outputs for the cycle after an edge that samples r and rs
   task automatic model_next(input logic [2:0] r, input logic rs);
      bit abort;
      if (rs) begin
         go_idle();
         exp_period = 16'd0;
      end else if (cur_kind == K_IDLE) begin
         if (r != 3'b000) begin
            win = r[0] ? 0 : (r[1] ? 1 : 2);
            build_plan(win);
            exp_grant = 3'(1 << win);
            advance();
         end else begin
            exp_done = 3'b000;
         end
      end else if (cur_kind == K_DONE) begin
         go_idle();
      end else begin
         abort = (r[win] == 1'b0);
`ifdef PIEZO_PREEMPT_EN
         if ((int'(r) & ((1 << win) - 1)) != 0)
            abort = 1'b1;
`endif
         if (abort)
            go_idle();
         else
            advance();
      end
   endtask

   task automatic step(input logic [2:0] r, input logic rs);
      req = r;
      rst = rs;
      model_next(r, rs);
      @(negedge clk);
      cyc++;
      chk("outputs",
          {8'h00, grant, done, busy, tone_en, tone_period},
          {8'h00, exp_grant, exp_done, (cur_kind != K_IDLE), exp_en, exp_period});
   endtask

   task automatic hold(input logic [2:0] r, input int n);
      for (int i = 0; i < n; i++)
         step(r, 1'b0);
   endtask

   initial begin
      // Reset state
      for (int i = 0; i < 3; i++)
         step(3'b000, 1'b1);

      // Key beep alone, held long enough to see the one-cycle idle re-grant
      hold(3'b000, 4);
      hold(3'b010, 600);
      hold(3'b000, 50);

      // Full melody
      hold(3'b100, 30100);
      hold(3'b000, 20);

      // All three at once: alarm wins, then re-wins
      hold(3'b111, 2100);
      hold(3'b000, 20);

      // Melody dropped somewhere inside its third note
      hold(3'b100, 10100 + int'($urandom_range(0, 4800)));
      hold(3'b000, 30);

      // Alarm raised while melody plays
      hold(3'b100, 200 + int'($urandom_range(0, 3000)));
      hold(3'b101, 2500);
      hold(3'b000, 30);

      // Reset in the middle of a beep, request still held afterwards
      hold(3'b010, 20 + int'($urandom_range(0, 400)));
      step(3'b010, 1'b1);
      hold(3'b010, 600);
      hold(3'b000, 20);

      // Random request levels with occasional reset pulses
      for (int k = 0; k < 40; k++) begin
         logic [2:0] r;
         r = 3'($urandom_range(0, 7));
         hold(r, int'($urandom_range(1, 400)));
         if ($urandom_range(0, 7) == 0)
            step(r, 1'b1);
      end
      hold(3'b000, 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
